wash_phase_timer: RTL and testbench



---
 rtl/wash_phase_timer.sv | 109 ++++++++++
 tb/tb_wash_phase_timer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Per-phase duration timer for the washing machine controller: emits a one-cycle
// Time_Event when the current phase expires, and can park/restore a spin remainder.
module wash_phase_timer #(
  parameter int FILL_CYCLES  = 8,
  parameter int WASH_CYCLES  = 16,
  parameter int RINSE_CYCLES = 12,
  parameter int SPIN_CYCLES  = 10,
  parameter int CNT_W        = 16
) (
  input  logic             Clk_D,
  input  logic             Rst,
  input  logic [2:0]       Timer_Encoding,
  input  logic             Pause_Enable,
  output logic             Time_Event,
  output logic [CNT_W-1:0] Remaining,
  output logic             Timer_Paused,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_RUN    = 2'd1,
    T_DONE   = 2'd2,
    T_PAUSED = 2'd3
  } state_t;

  localparam logic [2:0] ENC_FILL  = 3'b001;
  localparam logic [2:0] ENC_WASH  = 3'b010;
  localparam logic [2:0] ENC_RINSE = 3'b011;
  localparam logic [2:0] ENC_SPIN  = 3'b100;

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYCLES - 1);

  state_t           state;
  logic [2:0]       prev_enc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hold;

  logic             entry;
  logic             is_spin;
  logic             is_idle_enc;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    entry       = (Timer_Encoding != prev_enc);
    is_spin     = (Timer_Encoding == ENC_SPIN);
    is_idle_enc = 1'b1;
    load_val    = '0;
    case (Timer_Encoding)
      ENC_FILL:  begin load_val = FILL_LD;  is_idle_enc = 1'b0; end
      ENC_WASH:  begin load_val = WASH_LD;  is_idle_enc = 1'b0; end
      ENC_RINSE: begin load_val = RINSE_LD; is_idle_enc = 1'b0; end
      ENC_SPIN:  begin load_val = SPIN_LD;  is_idle_enc = 1'b0; end
      default:   begin load_val = '0;       is_idle_enc = 1'b1; end
    endcase
  end

  // Entry cycles suppress the pulse so a zero count left over from the
  // previous phase can never fire against the new one.
  always_comb begin
    Time_Event   = (state == T_RUN) && !entry && (count == '0);
    Timer_Paused = (state == T_PAUSED);
    dbg_state    = state;
    case (state)
      T_RUN:    Remaining = count;
      T_PAUSED: Remaining = hold;
      default:  Remaining = '0;
    endcase
  end

  always_ff @(posedge Clk_D or negedge Rst) begin
    if (!Rst) begin
      state    <= T_IDLE;
      prev_enc <= 3'b000;
      count    <= '0;
      hold     <= '0;
    end else begin
      prev_enc <= Timer_Encoding;
      if (entry) begin
        if (!is_idle_enc) begin
          state <= T_RUN;
          if ((state == T_PAUSED) && is_spin) begin
            count <= hold;
          end else begin
            count <= load_val;
            hold  <= '0;
          end
        end else if (state != T_PAUSED) begin
          // A paused spin survives the FSM dropping to IDLE.
          state <= T_IDLE;
          count <= '0;
        end
      end else if (state == T_RUN) begin
        if (count == '0) begin
          state <= T_DONE;
        end else if (is_spin && Pause_Enable) begin
          hold  <= count;
          state <= T_PAUSED;
        end else begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: a deadline-based phase model checked every
// cycle, a pulse scoreboard of expected event cycles, and literal spot checks.
module tb_wash_phase_timer;

  localparam int CNT_W = 16;
  localparam int FILL  = 4;
  localparam int WASH  = 6;
  localparam int RINSE = 5;
  localparam int SPIN  = 8;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_DONE   = 2;
  localparam int M_PAUSED = 3;

  logic             Clk_D;
  logic             Rst;
  logic [2:0]       Timer_Encoding;
  logic             Pause_Enable;
  logic             Time_Event;
  logic [CNT_W-1:0] Remaining;
  logic             Timer_Paused;
  logic [1:0]       dbg_state;

  int n_vec;
  int n_err;
  int cyc;
  int pulse_cnt;
  int entry_cyc;
  logic [31:0] exp_q[$];

  // model state
  int         m_mode;
  int         m_dl;
  int         m_hold;
  logic [2:0] m_prev;

  wash_phase_timer #(
    .FILL_CYCLES (FILL),
    .WASH_CYCLES (WASH),
    .RINSE_CYCLES(RINSE),
    .SPIN_CYCLES (SPIN),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk_D         (Clk_D),
    .Rst           (Rst),
    .Timer_Encoding(Timer_Encoding),
    .Pause_Enable  (Pause_Enable),
    .Time_Event    (Time_Event),
    .Remaining     (Remaining),
    .Timer_Paused  (Timer_Paused),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter
  initial Clk_D = 1'b0;
  always #5 Clk_D = ~Clk_D;

  initial cyc = 0;
  always @(posedge Clk_D) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int dur_of(input logic [2:0] enc);
    case (enc)
      3'b001:  return FILL;
      3'b010:  return WASH;
      3'b011:  return RINSE;
      3'b100:  return SPIN;
      default: return 0;
    endcase
  endfunction

  // behavioural model: a running phase is a deadline cycle, not a counter
  always @(negedge Clk_D) begin
    logic entry;
    int   e_rem;
    int   ph_dur;
    if (!Rst) begin
      m_mode = M_IDLE;
      m_dl   = 0;
      m_hold = 0;
      m_prev = 3'b000;
      check("rst_event", int'(Time_Event), 0);
      check("rst_remaining", int'(Remaining), 0);
      check("rst_paused", int'(Timer_Paused), 0);
    end else begin
      entry  = (Timer_Encoding != m_prev);
      ph_dur = dur_of(Timer_Encoding);
      e_rem  = (m_mode == M_RUN) ? (m_dl - cyc) : (m_mode == M_PAUSED) ? m_hold : 0;
      check("model_event", int'(Time_Event),
            int'((m_mode == M_RUN) && !entry && (cyc == m_dl)));
      check("model_remaining", int'(Remaining), e_rem);
      check("model_paused", int'(Timer_Paused), int'(m_mode == M_PAUSED));
      if (entry) begin
        if (ph_dur != 0) begin
          if ((m_mode == M_PAUSED) && (Timer_Encoding == 3'b100)) begin
            m_dl = cyc + 1 + m_hold;
          end else begin
            m_dl   = cyc + ph_dur;
            m_hold = 0;
          end
          m_mode = M_RUN;
        end else if (m_mode != M_PAUSED) begin
          m_mode = M_IDLE;
        end
      end else if (m_mode == M_RUN) begin
        if (cyc == m_dl) begin
          m_mode = M_DONE;
        end else if ((Timer_Encoding == 3'b100) && Pause_Enable) begin
          m_hold = m_dl - cyc;
          m_mode = M_PAUSED;
        end
      end
      m_prev = Timer_Encoding;
    end
  end

  // pulse scoreboard: every observed pulse must match the oldest expected cycle
  always @(negedge Clk_D) begin
    if (Rst && Time_Event) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("pulse_unexpected", 1, 0);
      else check("pulse_cycle", cyc, int'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic enter(input logic [2:0] enc);
    @(posedge Clk_D);
    #1;
    Timer_Encoding = enc;
    entry_cyc = cyc;
  endtask

  task automatic enter_expect(input logic [2:0] enc, input int lat);
    enter(enc);
    exp_q.push_back(32'(entry_cyc + lat));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk_D);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("pulse_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk_D);
    #1;
  endtask

  initial begin
    int p0;
    n_vec = 0;
    n_err = 0;
    pulse_cnt = 0;
    entry_cyc = 0;
    Rst = 1'b0;
    Timer_Encoding = 3'b000;
    Pause_Enable = 1'b0;
    idle_cycles(3);
    Rst = 1'b1;

    // reset mid-wash
    enter(3'b010);
    idle_cycles(3);
    check("rem_before_reset", int'(Remaining), 3);
    #2;
    Rst = 1'b0;
    Timer_Encoding = 3'b000;
    #1;
    check("async_rst_event", int'(Time_Event), 0);
    check("async_rst_remaining", int'(Remaining), 0);
    check("async_rst_paused", int'(Timer_Paused), 0);
    idle_cycles(2);
    Rst = 1'b1;
    p0 = pulse_cnt;
    repeat (20) @(negedge Clk_D);
    check("no_pulse_after_reset", pulse_cnt - p0, 0);

    // normal sequence, next phase one cycle after each pulse
    enter_expect(3'b001, 4); wait_drain();
    enter_expect(3'b010, 6); wait_drain();
    enter_expect(3'b011, 5); wait_drain();
    enter_expect(3'b100, 8); wait_drain();

    // hold wash encoding long after its pulse
    p0 = pulse_cnt;
    enter_expect(3'b010, 6); wait_drain();
    repeat (20) @(negedge Clk_D);
    check("hold_one_pulse", pulse_cnt - p0, 1);
    check("hold_remaining", int'(Remaining), 0);

    // double wash
    enter_expect(3'b011, 5); wait_drain();
    enter_expect(3'b010, 6); wait_drain();
    enter_expect(3'b011, 5); wait_drain();

    // pause spin at E+3 then idle, then resume
    enter(3'b100);
    idle_cycles(3);
    Pause_Enable = 1'b1;
    check("rem_at_pause", int'(Remaining), 5);
    idle_cycles(1);
    Pause_Enable = 1'b0;
    Timer_Encoding = 3'b000;
    check("paused_now", int'(Timer_Paused), 1);
    p0 = pulse_cnt;
    idle_cycles(10);
    check("paused_held", int'(Timer_Paused), 1);
    check("paused_rem", int'(Remaining), 5);
    check("paused_no_pulse", pulse_cnt - p0, 0);
    enter_expect(3'b100, 6); wait_drain();
    check("resume_unpaused", int'(Timer_Paused), 0);

    // pause then new coin cycle discards the remainder
    enter(3'b000);
    enter(3'b100);
    idle_cycles(2);
    Pause_Enable = 1'b1;
    idle_cycles(1);
    Pause_Enable = 1'b0;
    Timer_Encoding = 3'b000;
    idle_cycles(3);
    check("coin_paused_rem", int'(Remaining), 6);
    enter_expect(3'b001, 4); wait_drain();
    check("coin_unpaused", int'(Timer_Paused), 0);
    check("coin_remaining", int'(Remaining), 0);

    // pause coinciding with expiry: event wins
    enter(3'b000);
    enter_expect(3'b100, 8);
    idle_cycles(8);
    Pause_Enable = 1'b1;
    wait_drain();
    Pause_Enable = 1'b0;
    idle_cycles(1);
    check("expiry_beats_pause", int'(Timer_Paused), 0);

    // pause ignored outside spin
    Pause_Enable = 1'b1;
    enter_expect(3'b010, 6); wait_drain();
    Pause_Enable = 1'b0;

    // invalid encoding behaves as idle
    p0 = pulse_cnt;
    enter(3'b101);
    repeat (10) @(negedge Clk_D);
    check("invalid_no_pulse", pulse_cnt - p0, 0);
    check("invalid_remaining", int'(Remaining), 0);
    enter(3'b000);

    idle_cycles(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
